// File: rtl/can_bit_timing.sv
// CAN receive bit timing: synchronises rx, divides clk into time quanta and
// walks each bit through SYNC/TSEG1/TSEG2 with hard sync and SJW-limited resync.
module can_bit_timing #(
  parameter int BRP   = 4,
  parameter int TSEG1 = 6,
  parameter int TSEG2 = 3,
  parameter int SJW   = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  input  logic i_hard_sync_en,
  output logic o_rx_bit,
  output logic o_sample_pulse,
  output logic o_tx_point,
  output logic o_hard_sync
);

  typedef enum logic [1:0] {ST_SYNC, ST_TSEG1, ST_TSEG2} state_t;

  localparam logic [5:0] TQ_LAST  = 6'(BRP - 1);
  localparam logic [4:0] SEG1_LEN = 5'(TSEG1);
  localparam logic [4:0] SEG2_LEN = 5'(TSEG2);
  localparam logic [4:0] SJW_Q    = 5'(SJW);

  // Late-edge phase error saturated to the resync jump width.
  function automatic logic [2:0] sat_sjw(input logic [4:0] err);
    if (err > SJW_Q) return SJW_Q[2:0];
    return err[2:0];
  endfunction

  logic       r_rx_p0, r_rx_p1, r_rx_p2;
  state_t     r_state;
  logic [5:0] r_tq_cnt;
  logic [4:0] r_q_cnt;
  logic [2:0] r_ext, r_short;
  logic       r_resync_done;
  logic       r_rx_bit, r_sample_pulse, r_tx_point, r_hard_sync;

  logic       w_edge, w_hard, w_resync, w_late, w_early, w_early_restart, w_restart;
  logic       w_tq_tick, w_seg1_last, w_seg2_last;
  logic [2:0] w_ext_nx, w_short_nx;
  logic [4:0] w_early_err;

  // p1 is the synchronised bus level, p2 its one-cycle-old copy.
  assign w_edge   = r_rx_p2 & ~r_rx_p1 & r_rx_bit;
  assign w_hard   = i_hard_sync_en & w_edge;
  assign w_resync = w_edge & ~r_resync_done;
  assign w_late   = w_resync & (r_state == ST_TSEG1);
  assign w_early  = w_resync & (r_state == ST_TSEG2);

  assign w_early_err     = SEG2_LEN - r_q_cnt;
  assign w_early_restart = w_early & (w_early_err <= SJW_Q);
  assign w_restart       = w_hard | w_early_restart;

  assign w_ext_nx   = w_late ? sat_sjw(r_q_cnt + 5'd1) : r_ext;
  assign w_short_nx = (w_early & ~w_early_restart) ? SJW_Q[2:0] : r_short;

  // Segment ends use this cycle's correction so an edge on the final tick still counts.
  assign w_tq_tick   = (r_tq_cnt == TQ_LAST);
  assign w_seg1_last = (r_q_cnt == SEG1_LEN + {2'b00, w_ext_nx} - 5'd1);
  assign w_seg2_last = (r_q_cnt == SEG2_LEN - {2'b00, w_short_nx} - 5'd1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_p0        <= 1'b1;
      r_rx_p1        <= 1'b1;
      r_rx_p2        <= 1'b1;
      r_state        <= ST_SYNC;
      r_tq_cnt       <= '0;
      r_q_cnt        <= '0;
      r_ext          <= '0;
      r_short        <= '0;
      r_resync_done  <= 1'b0;
      r_rx_bit       <= 1'b1;
      r_sample_pulse <= 1'b0;
      r_tx_point     <= 1'b0;
      r_hard_sync    <= 1'b0;
    end else begin
      r_rx_p0        <= i_rx;
      r_rx_p1        <= r_rx_p0;
      r_rx_p2        <= r_rx_p1;
      r_sample_pulse <= 1'b0;
      r_tx_point     <= 1'b0;
      r_hard_sync    <= 1'b0;
      if (w_restart) begin
        r_state       <= ST_SYNC;
        r_tq_cnt      <= '0;
        r_q_cnt       <= '0;
        r_ext         <= '0;
        r_short       <= '0;
        r_resync_done <= 1'b1;
        r_tx_point    <= 1'b1;
        r_hard_sync   <= w_hard;
      end else begin
        r_ext   <= w_ext_nx;
        r_short <= w_short_nx;
        if (w_resync) r_resync_done <= 1'b1;
        if (w_tq_tick) begin
          r_tq_cnt <= '0;
          case (r_state)
            ST_SYNC: begin
              r_state <= ST_TSEG1;
              r_q_cnt <= '0;
            end
            ST_TSEG1: begin
              if (w_seg1_last) begin
                r_state        <= ST_TSEG2;
                r_q_cnt        <= '0;
                r_rx_bit       <= r_rx_p1;
                r_sample_pulse <= 1'b1;
                r_resync_done  <= 1'b0;
              end else begin
                r_q_cnt <= r_q_cnt + 5'd1;
              end
            end
            ST_TSEG2: begin
              if (w_seg2_last) begin
                r_state    <= ST_SYNC;
                r_q_cnt    <= '0;
                r_ext      <= '0;
                r_short    <= '0;
                r_tx_point <= 1'b1;
              end else begin
                r_q_cnt <= r_q_cnt + 5'd1;
              end
            end
            default: begin
              r_state <= ST_SYNC;
              r_q_cnt <= '0;
            end
          endcase
        end else begin
          r_tq_cnt <= r_tq_cnt + 6'd1;
        end
      end
    end
  end

  assign o_rx_bit       = r_rx_bit;
  assign o_sample_pulse = r_sample_pulse;
  assign o_tx_point     = r_tx_point;
  assign o_hard_sync    = r_hard_sync;

endmodule

// File: tb/tb_can_bit_timing.sv
// Scoreboard bench for can_bit_timing with default parameters (40 clk per bit).
// Expected strobe events are queued with stimulus and popped as the DUT emits them.
module tb_can_bit_timing;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic hse = 1'b0;
  logic rx_bit, sample_pulse, tx_point, hard_sync;

  int cyc = 0;
  int base = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         c;
    logic [2:0] kind;   // {hard_sync, tx_point, sample_pulse}
    logic       rxb;
  } exp_t;

  exp_t sb[$];

  localparam logic [2:0] K_SP = 3'b001;
  localparam logic [2:0] K_TX = 3'b010;
  localparam logic [2:0] K_HS = 3'b110;

  can_bit_timing #(.BRP(4), .TSEG1(6), .TSEG2(3), .SJW(1)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_rx           (rx),
    .i_hard_sync_en (hse),
    .o_rx_bit       (rx_bit),
    .o_sample_pulse (sample_pulse),
    .o_tx_point     (tx_point),
    .o_hard_sync    (hard_sync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc - base);
    end
  endtask

  task automatic expect_evt(input int c, input logic [2:0] kind, input logic rxb);
    exp_t e;
    e.c = c; e.kind = kind; e.rxb = rxb;
    sb.push_back(e);
  endtask

  // Advance to 1 time unit after the posedge that starts cycle c.
  task automatic wait_to(input int c);
    while (cyc - base < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-clock reset; cycle 0 is the cycle it is released in.
  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = cyc;
    chk_val("rst_rx_bit", int'(rx_bit), 1);
    chk_val("rst_sample_pulse", int'(sample_pulse), 0);
    chk_val("rst_tx_point", int'(tx_point), 0);
    chk_val("rst_hard_sync", int'(hard_sync), 0);
  endtask

  task automatic drain(input string tag);
    chk_val(tag, sb.size(), 0);
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (sample_pulse === 1'b1 || tx_point === 1'b1 || hard_sync === 1'b1)) begin
      if (sb.size() == 0) begin
        chk_val("unexpected_evt", int'({hard_sync, tx_point, sample_pulse}), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk_val("evt_cycle", cyc - base, e.c);
        chk_val("evt_kind", int'({hard_sync, tx_point, sample_pulse}), int'(e.kind));
        if (e.kind[0]) chk_val("evt_rx_bit", int'(rx_bit), int'(e.rxb));
      end
    end
  end

  initial begin
    // Free run: nominal 40-clk bits, recessive bus.
    do_reset();
    expect_evt(28, K_SP, 1'b1);
    expect_evt(40, K_TX, 1'b0);
    expect_evt(68, K_SP, 1'b1);
    expect_evt(80, K_TX, 1'b0);
    expect_evt(108, K_SP, 1'b1);
    wait_to(112);
    drain("free_run_left");

    // Hard sync: rx drops at the end of cycle 17, edge seen in cycle 20.
    do_reset();
    hse = 1'b1;
    expect_evt(21, K_HS, 1'b0);
    expect_evt(49, K_SP, 1'b0);
    expect_evt(61, K_TX, 1'b0);
    expect_evt(89, K_SP, 1'b0);
    wait_to(18); rx = 1'b0;
    wait_to(92);
    drain("hard_sync_left");
    hse = 1'b0; rx = 1'b1;

    // Late edge at TSEG1 q_cnt=2 (cycle 13) stretches the bit by one tq;
    // a second edge at cycle 24 in the same bit must be ignored.
    do_reset();
    expect_evt(32, K_SP, 1'b1);
    expect_evt(44, K_TX, 1'b0);
    expect_evt(72, K_SP, 1'b1);
    expect_evt(84, K_TX, 1'b0);
    wait_to(11); rx = 1'b0;
    wait_to(20); rx = 1'b1;
    wait_to(22); rx = 1'b0;
    wait_to(26); rx = 1'b1;
    wait_to(88);
    drain("late_edge_left");

    // Early edge at TSEG2 q_cnt=2 (cycle 37): restart, tx_point next cycle.
    do_reset();
    expect_evt(28, K_SP, 1'b1);
    expect_evt(38, K_TX, 1'b0);
    expect_evt(66, K_SP, 1'b1);
    expect_evt(78, K_TX, 1'b0);
    wait_to(35); rx = 1'b0;
    wait_to(40); rx = 1'b1;
    wait_to(82);
    drain("early_restart_left");

    // Early edge at TSEG2 q_cnt=0 (cycle 29): TSEG2 shortened by one tq.
    do_reset();
    expect_evt(28, K_SP, 1'b1);
    expect_evt(36, K_TX, 1'b0);
    expect_evt(64, K_SP, 1'b1);
    expect_evt(76, K_TX, 1'b0);
    wait_to(27); rx = 1'b0;
    wait_to(32); rx = 1'b1;
    wait_to(78);
    drain("early_short_left");

    // Edge in SYNC (cycle 2) gives no correction; a falling edge at cycle 36
    // while rx_bit=0 is not an edge at all.
    do_reset();
    rx = 1'b0;
    expect_evt(28, K_SP, 1'b0);
    expect_evt(40, K_TX, 1'b0);
    expect_evt(68, K_SP, 1'b1);
    expect_evt(80, K_TX, 1'b0);
    wait_to(30); rx = 1'b1;
    wait_to(34); rx = 1'b0;
    wait_to(50); rx = 1'b1;
    wait_to(84);
    drain("dominant_guard_left");

    // Reset in TSEG1 of the second bit with rx_bit=0; timeline restarts.
    do_reset();
    rx = 1'b0;
    expect_evt(28, K_SP, 1'b0);
    expect_evt(40, K_TX, 1'b0);
    wait_to(50);
    drain("pre_reset_left");
    rx = 1'b1;
    do_reset();
    expect_evt(28, K_SP, 1'b1);
    expect_evt(40, K_TX, 1'b0);
    wait_to(44);
    drain("post_reset_left");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/can_bit_timing.md
# can_bit_timing

Receive-side bit timing for the CAN controller: the counterpart of the fixed transmit baud divider. Synchronises the raw bus input, divides `clk` into time quanta, and tracks each bit through SYNC/TSEG1/TSEG2. On recessive-to-dominant edges it hard-syncs or resyncs to the remote transmitter. It supplies the MAC with a sampled bit plus sample-point and bit-start strobes.

## Interface
- `BRP`, 4: clk cycles per time quantum (tq); legal range 1..64.
- `TSEG1`, 6: prop+phase1 length in tq; legal range 2..16.
- `TSEG2`, 3: phase2 length in tq; legal range 2..8.
- `SJW`, 1: resync jump width in tq; legal range 1..4, must be ≤ TSEG2.
- Nominal bit time is (1+TSEG1+TSEG2)·BRP clk. With defaults this is 40 clk, i.e. 500 kbit/s at 20 MHz.
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: synchronous reset, active-low.
- `rx` in 1: raw CAN bus input, asynchronous. 1 = recessive.
- `hard_sync_en` in 1: from MAC; high while bus idle/intermission, so the next falling edge hard-syncs.
- `rx_bit` out 1: bit value captured at the last sample point.
- `sample_pulse` out 1: one-clk strobe; `rx_bit` is valid from this cycle.
- `tx_point` out 1: one-clk strobe at bit start; the transmitter drives its next bit here.
- `hard_sync` out 1: one-clk strobe when a hard sync occurred.

## Operation
- **Input synchroniser:**
  - 2-flop synchroniser on `rx` gives `rx_s`; a third flop gives `rx_d`. All three reset to 1.
- **Edge detection:**
  - `edge` = `rx_d`==1 && `rx_s`==0 && `rx_bit`==1, i.e. a falling edge while the last sampled bit was recessive.
- **Prescaler:**
  - `tq_cnt` counts 0..BRP-1. `tq_tick` fires when `tq_cnt`==BRP-1.
- **FSM and quantum counter:**
  - States are SYNC, TSEG1, TSEG2. `q_cnt` counts quanta within the current segment.
  - SYNC lasts 1 tq, TSEG1 lasts TSEG1+ext tq, TSEG2 lasts TSEG2-short tq. `ext` and `short` are cleared on entering SYNC.
  - Order of transitions: SYNC→TSEG1→TSEG2→SYNC, each taken on `tq_tick` at the last quantum of the segment.
- **Sample point (TSEG1→TSEG2):**
  - `rx_bit` <= `rx_s`.
  - `sample_pulse` is high in the first TSEG2 cycle.
  - `resync_done` is cleared.
- **Bit start (→SYNC):**
  - `tx_point` is high in the first SYNC cycle.
- **Edge handling:** at most one per bit; `resync_done` is set by any handled edge. Priority is top to bottom.
  1. `hard_sync_en` && `edge`, in any state: restart.
     - State becomes SYNC; `tq_cnt`, `q_cnt`, `ext` and `short` are set to 0.
     - `tx_point` and `hard_sync` pulse next cycle.
     - This rule ignores `resync_done`.
  2. `edge` in SYNC: no correction.
  3. `edge` in TSEG1 at `q_cnt`=k (late edge): `ext` = min(k+1, SJW). The sample point moves out accordingly.
  4. `edge` in TSEG2 at `q_cnt`=k (early edge), with magnitude e = TSEG2-k:
     - If e ≤ SJW: restart exactly as hard sync, but `hard_sync` is not pulsed.
     - Otherwise: `short` = SJW.
- **Simultaneity rules:**
  - An edge coinciding with the final `tq_tick` of TSEG2 takes rule 4; restart beats the normal SYNC entry.
  - An edge on the final tick of TSEG1 takes rule 3: TSEG1 is extended and the sample point is deferred.
- **Edges when `resync_done`=1:** ignored except under rule 1.
- **Arithmetic:**
  - Counters are sized by clog2 of their parameter maxima: `tq_cnt` 6 b, `q_cnt` 5 b.
  - Segment-end compares use TSEG1+ext and TSEG2-short without wrap. Parameter legality guarantees TSEG2-short ≥ 1.

## Timing
- **Reset (`rst_n` low at a clk edge), next cycle:**
  - `rx_bit`=1.
  - `sample_pulse`, `tx_point` and `hard_sync` = 0.
  - State SYNC; all counters, `ext`, `short` and `resync_done` = 0.
- Reset mid-bit abandons the bit. There is no `tx_point` pulse on reset exit.
- Cycle 0 is the first cycle with `rst_n`=1. With defaults and no edges:
  - SYNC spans cycles 0-3, TSEG1 cycles 4-27, TSEG2 cycles 28-39.
  - `sample_pulse` at 28, 68, 108…
  - `tx_point` at 40, 80…
- Pin-to-`edge` latency is 3 clk, since `edge` is seen when `rx_s` falls. Restart outputs follow 1 clk after `edge`.
- All outputs are registered and pulses are exactly 1 clk wide.

## Test plan
- **Free run:** reset, then `rx`=1 constantly with defaults → `sample_pulse` at cycles 28, 68, 108; `tx_point` at 40, 80; `rx_bit` stays 1; `hard_sync` never asserts.
- **Hard sync:** `hard_sync_en`=1, `rx` falls at cycle 17 → `hard_sync` and `tx_point` at cycle 21, `sample_pulse` at 49, `rx_bit`=0 at 49.
- **Late-edge resync:** `hard_sync_en`=0, `rx_bit`=1, `rx` falls so that `edge` lands in TSEG1 `q_cnt`=2 → TSEG1 extended by 1 tq; `sample_pulse` is 4 clk later than nominal; following `tx_point` also +4.
- **Early-edge resync:** `edge` at TSEG2 `q_cnt`=2 (e=1, SJW=1) → restart, `tx_point` next cycle, no `hard_sync`. With `edge` at `q_cnt`=0 (e=3) → TSEG2 is shortened to 2 tq and `tx_point` comes 4 clk early.
- **One-per-bit and dominant guard:** a second edge in the same bit, or an edge while `rx_bit`=0 → no change to nominal timing.
- **Reset mid-TSEG1:** `rst_n` low for 1 clk at cycle 10 → all outputs are at reset values next cycle and the timeline restarts from cycle 0.
